// File: rtl/pixel_dither_rgb565.sv
// RGB888 -> RGB565 reducer with LFSR dither, 2-stage valid/ready pipeline with frame/line sideband.
// Optional macro DITHER_RUNTIME_CTRL_EN adds i_dither_en to gate the noise per accepted pixel.
module pixel_dither_rgb565 #(
   parameter int PIPE_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [4:0]  i_noise,
`ifdef DITHER_RUNTIME_CTRL_EN
   input  logic        i_dither_en,
`endif
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [23:0] i_rgb,
   input  logic        i_sof,
   input  logic        i_eol,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_rgb565,
   output logic        o_sof,
   output logic        o_eol,
   output logic [15:0] o_pix_count
);

   // r_vld[0] = stage-1 occupied, r_vld[1] = stage-2 (output) occupied
   logic [PIPE_STAGES-1:0] r_vld;
   logic [8:0]  r_s1_r;
   logic [8:0]  r_s1_g;
   logic [8:0]  r_s1_b;
   logic        r_s1_sof;
   logic        r_s1_eol;
   logic [15:0] r_s2_rgb;
   logic        r_s2_sof;
   logic        r_s2_eol;
   logic [15:0] r_pix_count;

   logic        w_s2_load;
   logic        w_in_acc;
   logic        w_out_xfer;
   logic [4:0]  w_noise;
   logic [8:0]  w_sum_r;
   logic [8:0]  w_sum_g;
   logic [8:0]  w_sum_b;
   logic [7:0]  w_sat_r;
   logic [7:0]  w_sat_g;
   logic [7:0]  w_sat_b;

`ifdef DITHER_RUNTIME_CTRL_EN
   assign w_noise = i_dither_en ? i_noise : 5'd0;
`else
   assign w_noise = i_noise;
`endif

   assign w_s2_load  = !r_vld[1] || i_ready;
   assign o_ready    = !r_vld[0] || w_s2_load;
   assign w_in_acc   = i_valid && o_ready;
   assign w_out_xfer = r_vld[1] && i_ready;

   assign w_sum_r = {1'b0, i_rgb[23:16]} + {6'd0, w_noise[2:0]};
   assign w_sum_g = {1'b0, i_rgb[15:8]}  + {7'd0, w_noise[4:3]};
   assign w_sum_b = {1'b0, i_rgb[7:0]}   + {6'd0, w_noise[0], w_noise[4], w_noise[1]};

   // Carry out of the 8-bit channel means the noise pushed it past full scale
   assign w_sat_r = r_s1_r[8] ? 8'hFF : r_s1_r[7:0];
   assign w_sat_g = r_s1_g[8] ? 8'hFF : r_s1_g[7:0];
   assign w_sat_b = r_s1_b[8] ? 8'hFF : r_s1_b[7:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vld       <= '0;
         r_s1_r      <= 9'd0;
         r_s1_g      <= 9'd0;
         r_s1_b      <= 9'd0;
         r_s1_sof    <= 1'b0;
         r_s1_eol    <= 1'b0;
         r_s2_rgb    <= 16'd0;
         r_s2_sof    <= 1'b0;
         r_s2_eol    <= 1'b0;
         r_pix_count <= 16'd0;
      end else begin
         if (w_in_acc) begin
            r_vld[0] <= 1'b1;
            r_s1_r   <= w_sum_r;
            r_s1_g   <= w_sum_g;
            r_s1_b   <= w_sum_b;
            r_s1_sof <= i_sof;
            r_s1_eol <= i_eol;
         end else if (w_s2_load) begin
            r_vld[0] <= 1'b0;
         end

         if (w_s2_load) begin
            r_vld[1] <= r_vld[0];
            if (r_vld[0]) begin
               r_s2_rgb <= {w_sat_r[7:3], w_sat_g[7:2], w_sat_b[7:3]};
               r_s2_sof <= r_s1_sof;
               r_s2_eol <= r_s1_eol;
            end
         end

         if (w_out_xfer) begin
            r_pix_count <= r_s2_sof ? 16'd0 : r_pix_count + 16'd1;
         end
      end
   end

   assign o_valid     = r_vld[1];
   assign o_rgb565    = r_s2_rgb;
   assign o_sof       = r_s2_sof;
   assign o_eol       = r_s2_eol;
   assign o_pix_count = r_pix_count;

endmodule
